// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and control-field layout for pipe_stage_buf
package pipe_pkg;

   // Occupancy of the two-entry stage: nothing, main only, main plus skid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // Bit positions inside the control field
   localparam int CTRL_MEMWRITE  = 0;
   localparam int CTRL_MEMREAD   = 1;
   localparam int CTRL_REGSRC_LO = 2;
   localparam int CTRL_REGSRC_HI = 3;

   localparam int CTRL_W_DEF = 4;
   typedef logic [CTRL_W_DEF-1:0] ctrl_t;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one payload register with load enable, valid bit and sync clear
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int W = 68
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         drop,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   logic [W-1:0] data_q, data_d;
   logic         valid_q, valid_d;

   // Clear wins over load; the payload is kept on clear so a squashed head still shows its last value
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clr) begin
         valid_d = 1'b0;
      end else if (load) begin
         data_d  = d;
         valid_d = 1'b1;
      end else if (drop) begin
         valid_d = 1'b0;
      end
   end

   // Reset zeroes both payload and valid
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q     = data_q;
   assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic pipeline register with 2-entry skid buffer; PIPE_STATS_EN adds stall/bubble counters
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int CTRL_W = $bits(ctrl_t)
`ifdef PIPE_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STATS_EN
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt,
`endif
   output logic [CTRL_W-1:0] out_ctrl
);

   localparam int PW = DATA_W + CTRL_W;

   state_e          state_q, state_d;
   logic [PW-1:0]   main_q, skid_q, main_in, beat_in;
   logic            main_valid, skid_valid;
   logic            main_load, main_drop, main_from_skid;
   logic            skid_load, skid_drop;
   logic            accept, emit;

   assign beat_in   = {in_ctrl, in_data};
   assign in_ready  = (state_q != TWO);
   assign out_valid = main_valid;
   assign accept    = in_valid & in_ready;
   assign emit      = out_valid & out_ready;
   assign main_in   = main_from_skid ? skid_q : beat_in;

   // Next occupancy and entry moves; flush overrides both accept and emit
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_drop      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_load = 1'b1;
                  state_d   = ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_load = 1'b1;
               end else if (accept) begin
                  skid_load = 1'b1;
                  state_d   = TWO;
               end else if (emit) begin
                  main_drop = 1'b1;
                  state_d   = EMPTY;
               end
            end
            TWO: begin
               if (emit) begin
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
                  skid_drop      = 1'b1;
                  state_d        = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Occupancy register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   pipe_entry #(.W(PW)) u_main (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .load  (main_load),
      .drop  (main_drop),
      .d     (main_in),
      .q     (main_q),
      .valid (main_valid)
   );

   pipe_entry #(.W(PW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .load  (skid_load),
      .drop  (skid_drop),
      .d     (beat_in),
      .q     (skid_q),
      .valid (skid_valid)
   );

   // Bubbles carry all-zero control so they can never write memory or the register file
   assign out_data = main_q[DATA_W-1:0];
   assign out_ctrl = main_valid ? main_q[PW-1:DATA_W] : '0;

`ifdef PIPE_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Saturating stall/bubble counts; flush does not clear them
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (!out_valid && (bubble_cnt_q != CNT_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   logic unused_skid_valid;
   assign unused_skid_valid = skid_valid;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - queue-model self-checking bench for pipe_stage_buf
`timescale 1ns/1ps
module tb_pipe_stage_buf;

   localparam int DW = 64;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, out_ready;
   logic [DW-1:0] in_data;
   logic [CW-1:0] in_ctrl;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;

   always #5 clk = ~clk;

`ifdef PIPE_STATS_EN
   logic [15:0]   stall_cnt, bubble_cnt;
   logic [1:0]    stall_cnt2, bubble_cnt2;
   logic          in_ready2, out_valid2;
   logic [DW-1:0] out_data2;
   logic [CW-1:0] out_ctrl2;
`endif

   pipe_stage_buf dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
`ifdef PIPE_STATS_EN
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt),
`endif
      .out_ctrl   (out_ctrl)
   );

`ifdef PIPE_STATS_EN
   pipe_stage_buf #(.CNT_W(2)) dut2 (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready2),
      .in_data    (in_data),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid2),
      .out_ready  (out_ready),
      .out_data   (out_data2),
      .stall_cnt  (stall_cnt2),
      .bubble_cnt (bubble_cnt2),
      .out_ctrl   (out_ctrl2)
   );
`endif

   int total = 0;
   int bad   = 0;

   // model: FIFO of at most two {ctrl,data} beats, plus stat counts
   logic [DW+CW-1:0] mq[$];
   logic [DW-1:0]    seen[$];
   bit               live = 1'b0;
   int               m_stall = 0, m_bubble = 0, m_stall2 = 0, m_bubble2 = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] exp_ctrl();
      if (mq.size() == 0) return '0;
      return mq[0][DW+CW-1:DW];
   endfunction

   function automatic logic [DW-1:0] exp_data();
      if (mq.size() == 0) return '0;
      return mq[0][DW-1:0];
   endfunction

   // model update at each edge from the inputs and the model's own occupancy
   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
         live      <= 1'b1;
         m_stall   <= 0;
         m_bubble  <= 0;
         m_stall2  <= 0;
         m_bubble2 <= 0;
      end else begin
         if (mq.size() != 0 && !out_ready) begin
            if (m_stall < 65535) m_stall <= m_stall + 1;
            if (m_stall2 < 3) m_stall2 <= m_stall2 + 1;
         end
         if (mq.size() == 0) begin
            if (m_bubble < 65535) m_bubble <= m_bubble + 1;
            if (m_bubble2 < 3) m_bubble2 <= m_bubble2 + 1;
         end
         if (flush) begin
            mq.delete();
         end else if (mq.size() == 2) begin
            if (out_ready) void'(mq.pop_front());
         end else begin
            if (mq.size() == 1 && out_ready) void'(mq.pop_front());
            if (in_valid) mq.push_back({in_ctrl, in_data});
         end
      end
   end

   // record every beat the DUT hands downstream
   always @(posedge clk) begin
      if (rst && !flush && out_valid && out_ready) seen.push_back(out_data);
   end

   // per-cycle comparison against the model
   always @(negedge clk) begin
      if (live) begin
         check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         check("in_ready", 64'(in_ready), 64'(mq.size() < 2));
         check("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl()));
         if (mq.size() != 0) check("out_data", out_data, exp_data());
`ifdef PIPE_STATS_EN
         check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
         check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
         check("stall_cnt_w2", 64'(stall_cnt2), 64'(m_stall2));
         check("bubble_cnt_w2", 64'(bubble_cnt2), 64'(m_bubble2));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] rdy_pat = 32'b1011_0010_1110_0001_0110_1001_1100_0101;
   logic [31:0] vld_pat = 32'b1101_1110_0111_1011_0011_1101_1110_1110;

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 64'h77; in_ctrl = 4'hF; out_ready = 1'b1;

      // reset with a beat offered
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b1; in_valid = 1'b0;
      step();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // streaming, latency 1
      seen.delete();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = 64'(i); in_ctrl = CW'(i);
         step();
         check("stream_valid", 64'(out_valid), 64'd1);
         check("stream_data", out_data, 64'(i));
      end
      in_valid = 1'b0;
      step();
      step();
      check("stream_count", 64'(seen.size()), 64'd8);
      for (int j = 0; j < 8 && j < seen.size(); j++) check("stream_order", seen[j], 64'(j + 1));

      // skid: two beats against a stalled consumer
      seen.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hA; in_ctrl = 4'h1;
      step();
      in_data = 64'hB; in_ctrl = 4'h2;
      step();
      check("skid_in_ready", 64'(in_ready), 64'd0);
      check("skid_head", out_data, 64'hA);
      in_valid = 1'b0;
      step();
      out_ready = 1'b1;
      step();
      step();
      step();
      check("skid_count", 64'(seen.size()), 64'd2);
      if (seen.size() == 2) begin
         check("skid_first", seen[0], 64'hA);
         check("skid_second", seen[1], 64'hB);
      end

      // flush while full, with 0xC offered the same cycle
      seen.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 64'hD; in_ctrl = 4'h3;
      step();
      in_data = 64'hE;
      step();
      check("pre_flush_in_ready", 64'(in_ready), 64'd0);
      flush = 1'b1; in_data = 64'hC;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_out_ctrl", 64'(out_ctrl), 64'd0);
      out_ready = 1'b1;
      step();
      step();
      step();
      check("flush_no_beats", 64'(seen.size()), 64'd0);

      // bubbles with live-looking control on the input
      in_ctrl = 4'b0011; in_valid = 1'b0; in_data = 64'hDEAD;
      for (int k = 0; k < 4; k++) begin
         step();
         check("bubble_ctrl", 64'(out_ctrl), 64'd0);
         check("bubble_memwrite", 64'(out_ctrl[pipe_pkg::CTRL_MEMWRITE]), 64'd0);
         check("bubble_memread", 64'(out_ctrl[pipe_pkg::CTRL_MEMREAD]), 64'd0);
         check("bubble_regsrc", 64'(out_ctrl[pipe_pkg::CTRL_REGSRC_HI:pipe_pkg::CTRL_REGSRC_LO]), 64'd0);
      end

      // mixed valid/ready pattern, order checked by the model
      for (int k = 0; k < 32; k++) begin
         in_valid = vld_pat[k]; out_ready = rdy_pat[k];
         in_data = 64'h100 + 64'(k); in_ctrl = CW'(k);
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();
      step();
      check("drain_empty", 64'(out_valid), 64'd0);

      // reset mid-stream, then hold one beat against a stall
      out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h44;
      step();
      rst = 1'b0;
      step();
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", out_data, 64'd0);
      rst = 1'b1;
      in_valid = 1'b1; in_data = 64'h55; in_ctrl = 4'h1;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", out_data, 64'h55);
`ifdef PIPE_STATS_EN
      check("stall5", 64'(stall_cnt), 64'd5);
      check("bubble1", 64'(bubble_cnt), 64'd1);
`endif
      step();
`ifdef PIPE_STATS_EN
      check("stall6", 64'(stall_cnt), 64'd6);
      check("stall_sat", 64'(stall_cnt2), 64'd3);
`endif
      out_ready = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
